// File: rtl/bitlet_pkg.sv
// Shared types and default geometry for the bitlet scheduler sequencer.
package bitlet_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_VEC_LENGTH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        COMP = 1'b1
    } state_t;

endpackage

// File: rtl/bitlet_sched_ctrl_if.sv
// Weight-buffer handshake, scheduler strobes and PE-array beat handshake.
interface bitlet_sched_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned VEC_LENGTH = 16
);

    logic                                 w_valid;
    logic                                 w_ready;
    logic [DATA_WIDTH-1:0][VEC_LENGTH-1:0] weight;
    logic                                 wen_rf;
    logic                                 en_comp;
    logic                                 out_ready;
    logic                                 out_valid;
    logic                                 out_last;
    logic                                 tile_done;
    logic                                 busy;

    modport master (
        output w_valid, weight, out_ready,
        input  w_ready, wen_rf, en_comp, out_valid, out_last, tile_done, busy
    );

    modport slave (
        input  w_valid, weight, out_ready,
        output w_ready, wen_rf, en_comp, out_valid, out_last, tile_done, busy
    );

endinterface

// File: rtl/popcount_max.sv
// Largest per-column popcount of a weight tile; this is the tile's beat count.
module popcount_max
    import bitlet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned VEC_LENGTH = DEF_VEC_LENGTH,
    parameter int unsigned CNT_WIDTH  = $clog2(VEC_LENGTH + 1)
) (
    input  logic [DATA_WIDTH-1:0][VEC_LENGTH-1:0] weight,
    output logic [CNT_WIDTH-1:0]                  maxpop
);

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [VEC_LENGTH-1:0] v);
        logic [CNT_WIDTH-1:0] sum;
        sum = '0;
        for (int i = 0; i < int'(VEC_LENGTH); i++) begin
            sum = sum + CNT_WIDTH'(v[i]);
        end
        return sum;
    endfunction

    logic [CNT_WIDTH-1:0] pop [DATA_WIDTH];

    always_comb begin
        for (int j = 0; j < int'(DATA_WIDTH); j++) begin
            pop[j] = popcount(weight[j]);
        end
    end

    always_comb begin
        maxpop = '0;
        for (int j = 0; j < int'(DATA_WIDTH); j++) begin
            if (pop[j] > maxpop) begin
                maxpop = pop[j];
            end
        end
    end

endmodule

// File: rtl/bitlet_sched_ctrl.sv
// Tile sequencer: loads weight tiles, drains one essential bit per beat, and
// prefetches the next tile on the final beat so tiles stream without a bubble.
module bitlet_sched_ctrl
    import bitlet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned VEC_LENGTH = DEF_VEC_LENGTH,
    parameter int unsigned CNT_WIDTH  = $clog2(VEC_LENGTH + 1)
) (
    input logic               clk,
    input logic               reset,
    bitlet_sched_ctrl_if.slave bus
);

    logic [CNT_WIDTH-1:0] maxpop;

    popcount_max #(
        .DATA_WIDTH (DATA_WIDTH),
        .VEC_LENGTH (VEC_LENGTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_popcount_max (
        .weight (bus.weight),
        .maxpop (maxpop)
    );

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 tile_done_q, tile_done_d;

    logic stall, fire, last_fire, w_ready, load, cnt_one;

    always_comb begin
        cnt_one   = (cnt_q == CNT_WIDTH'(1));
        stall     = out_valid_q & ~bus.out_ready;
        fire      = (state_q == COMP) & ~stall;
        last_fire = fire & cnt_one;
        // IDLE acceptance deliberately ignores stall: loading never disturbs the held beat.
        w_ready   = (state_q == IDLE) | last_fire;
        load      = bus.w_valid & w_ready;

        state_d = state_q;
        cnt_d   = cnt_q;
        if (fire) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
            if (cnt_one) begin
                state_d = IDLE;
            end
        end
        if (load) begin
            if (maxpop == '0) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = COMP;
                cnt_d   = maxpop;
            end
        end

        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (fire) begin
            out_valid_d = 1'b1;
            out_last_d  = cnt_one;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        tile_done_d = (out_valid_q & out_last_q & bus.out_ready) | (load & (maxpop == '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            tile_done_q <= tile_done_d;
        end
    end

    assign bus.w_ready   = w_ready;
    assign bus.wen_rf    = load;
    assign bus.en_comp   = fire;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.tile_done = tile_done_q;
    assign bus.busy      = (state_q == COMP);

endmodule

// File: tb/tb_bitlet_sched_ctrl.sv
// Self-checking bench for bitlet_sched_ctrl: directed latency scenarios plus a
// randomized stream checked against a tile/beat scoreboard.
module tb_bitlet_sched_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned VL = 16;

    typedef logic [DW-1:0][VL-1:0] tile_t;

    logic clk;
    logic reset;

    bitlet_sched_ctrl_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) bus ();

    bitlet_sched_ctrl #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks;
    int passes;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VL-1:0] col_mask(input int k);
        logic [VL-1:0] m;
        m = '0;
        while ($countones(m) < k) m[$urandom_range(VL - 1, 0)] = 1'b1;
        return m;
    endfunction

    // Random tile whose largest column popcount is exactly n.
    function automatic tile_t make_tile(input int n);
        tile_t t;
        int    pick;
        pick = $urandom_range(DW - 1, 0);
        for (int j = 0; j < int'(DW); j++) begin
            t[j] = col_mask((j == pick) ? n : $urandom_range(n, 0));
        end
        return t;
    endfunction

    // Observation vector: {w_ready, wen_rf, en_comp, out_valid, out_last, tile_done, busy}
    function automatic logic [6:0] obs();
        return {bus.w_ready, bus.wen_rf, bus.en_comp, bus.out_valid, bus.out_last,
                bus.tile_done, bus.busy};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.w_valid = 1'b0;
        bus.weight = '0;
        bus.out_ready = 1'b1;
        #7;
        checks++;
        if (obs() !== 7'b1000000) $display("FAIL reset_state got=%b want=%b", obs(), 7'b1000000);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (obs() !== 7'b1000000) $display("FAIL post_reset got=%b want=%b", obs(), 7'b1000000);
        else passes++;
    endtask

    // Single tile from idle with out_ready=1, checked cycle by cycle against the latency rules.
    task automatic run_tile(input string name, input tile_t t, input int n);
        logic [6:0] exp;
        for (int c = 0; c <= n + 3; c++) begin
            @(negedge clk);
            bus.w_valid = (c == 0);
            bus.weight = (c == 0) ? t : tile_t'({$urandom, $urandom, $urandom, $urandom});
            bus.out_ready = 1'b1;
            #1;
            exp[6] = (c == 0) || (c >= n);
            exp[5] = (c == 0);
            exp[4] = (c >= 1) && (c <= n);
            exp[3] = (c >= 2) && (c <= n + 1);
            exp[2] = (n > 0) && (c == n + 1);
            exp[1] = (n == 0) ? (c == 1) : (c == n + 2);
            exp[0] = (c >= 1) && (c <= n);
            checks++;
            if (obs() !== exp) $display("FAIL %s cyc=%0d got=%b want=%b", name, c, obs(), exp);
            else passes++;
        end
    endtask

    task automatic test_single();
        tile_t t;
        t[0] = col_mask(3); t[1] = col_mask(1); t[2] = '0; t[3] = col_mask(2);
        t[4] = '0; t[5] = '0; t[6] = col_mask(1); t[7] = '0;
        run_tile("single_tile", t, 3);
    endtask

    task automatic test_zero_tile();
        run_tile("zero_tile", '0, 0);
    endtask

    task automatic test_all_ones();
        run_tile("all_ones", '1, 16);
    endtask

    task automatic test_back_to_back();
        tile_t      a, b;
        logic [6:0] exp;
        a = make_tile(2);
        b = make_tile(16);
        for (int c = 0; c <= 22; c++) begin
            @(negedge clk);
            bus.w_valid = (c <= 2);
            bus.weight = (c == 0) ? a : b;
            bus.out_ready = 1'b1;
            #1;
            exp[6] = (c == 0) || (c == 2) || (c >= 18);
            exp[5] = (c == 0) || (c == 2);
            exp[4] = (c >= 1) && (c <= 18);
            exp[3] = (c >= 2) && (c <= 19);
            exp[2] = (c == 3) || (c == 19);
            exp[1] = (c == 4) || (c == 20);
            exp[0] = (c >= 1) && (c <= 18);
            checks++;
            if (obs() !== exp) $display("FAIL back_to_back cyc=%0d got=%b want=%b", c, obs(), exp);
            else passes++;
        end
    endtask

    task automatic test_stall();
        tile_t t;
        int    en_cnt, beats, done_cnt, last_at;
        logic  pv, pl;
        t = make_tile(4);
        en_cnt = 0; beats = 0; done_cnt = 0; last_at = -1; pv = 1'b0; pl = 1'b0;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            bus.w_valid = (c == 0);
            bus.weight = t;
            bus.out_ready = !((c >= 3) && (c <= 5));
            #1;
            if (!bus.out_ready) begin
                checks++;
                if (bus.en_comp !== 1'b0 || bus.out_valid !== 1'b1)
                    $display("FAIL stall_hold cyc=%0d en_comp=%b out_valid=%b want 0/1",
                             c, bus.en_comp, bus.out_valid);
                else passes++;
            end
            if (c >= 4 && c <= 6) begin
                checks++;
                if ({bus.out_valid, bus.out_last} !== {pv, pl})
                    $display("FAIL stall_held_beat cyc=%0d got=%b want=%b",
                             c, {bus.out_valid, bus.out_last}, {pv, pl});
                else passes++;
            end
            en_cnt += int'(bus.en_comp);
            done_cnt += int'(bus.tile_done);
            if (bus.out_valid && bus.out_ready) begin
                beats++;
                if (bus.out_last) last_at = beats;
            end
            pv = bus.out_valid;
            pl = bus.out_last;
        end
        checks++;
        if (en_cnt != 4) $display("FAIL stall_en_count got=%0d want=4", en_cnt);
        else passes++;
        checks++;
        if (beats != 4 || last_at != 4)
            $display("FAIL stall_beats got=%0d last_at=%0d want=4/4", beats, last_at);
        else passes++;
        checks++;
        if (done_cnt != 1) $display("FAIL stall_done got=%0d want=1", done_cnt);
        else passes++;
    endtask

    task automatic test_reset_mid_tile();
        tile_t t;
        t = make_tile(8);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            bus.w_valid = (c == 0);
            bus.weight = t;
            bus.out_ready = 1'b1;
        end
        #1;
        checks++;
        if ({bus.busy, bus.out_valid} !== 2'b11)
            $display("FAIL pre_abort got=%b want=11", {bus.busy, bus.out_valid});
        else passes++;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== 7'b1000000) $display("FAIL async_abort got=%b want=%b", obs(), 7'b1000000);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs() !== 7'b1000000)
                $display("FAIL after_abort cyc=%0d got=%b want=%b", c, obs(), 7'b1000000);
            else passes++;
        end
        run_tile("after_abort_tile", make_tile(3), 3);
    endtask

    // Random stream: tiles of random beat count, random back-pressure; scoreboard of tiles.
    task automatic test_random();
        int    q[$];
        int    sent, seen, total_beats, en_cnt, cur_n, drain;
        tile_t cur_w;
        logic  pending, exp_done, acc_last, zero_load, exp_last, pv, pl, pr;
        sent = 0; seen = 0; total_beats = 0; en_cnt = 0; drain = 0; cur_n = 0; cur_w = '0;
        pending = 1'b0; exp_done = 1'b0; pv = 1'b0; pl = 1'b0; pr = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (!pending && sent < 40 && $urandom_range(3, 0) != 0) begin
                cur_n = ($urandom_range(4, 0) == 0) ? 16 : int'($urandom_range(16, 0));
                cur_w = make_tile(cur_n);
                pending = 1'b1;
                sent++;
            end
            bus.w_valid = pending;
            bus.weight = pending ? cur_w : tile_t'({$urandom, $urandom, $urandom, $urandom});
            bus.out_ready = ($urandom_range(3, 0) != 0);
            #1;
            checks++;
            if (bus.tile_done !== exp_done)
                $display("FAIL rand_tile_done cyc=%0d got=%b want=%b", cyc, bus.tile_done, exp_done);
            else passes++;
            checks++;
            if (bus.wen_rf !== (bus.w_valid & bus.w_ready))
                $display("FAIL rand_wen_rf cyc=%0d got=%b want=%b", cyc, bus.wen_rf,
                         bus.w_valid & bus.w_ready);
            else passes++;
            if (pv && !pr) begin
                checks++;
                if ({bus.out_valid, bus.out_last} !== {pv, pl})
                    $display("FAIL rand_hold cyc=%0d got=%b want=%b", cyc,
                             {bus.out_valid, bus.out_last}, {pv, pl});
                else passes++;
            end
            acc_last = 1'b0;
            zero_load = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL rand_spurious_beat cyc=%0d got=beat want=none", cyc);
                end else begin
                    seen++;
                    exp_last = (seen == q[0]);
                    if (bus.out_last !== exp_last)
                        $display("FAIL rand_out_last cyc=%0d got=%b want=%b", cyc, bus.out_last,
                                 exp_last);
                    else passes++;
                    if (exp_last) begin
                        acc_last = 1'b1;
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end
            if (bus.w_valid && bus.w_ready) begin
                pending = 1'b0;
                total_beats += cur_n;
                if (cur_n == 0) zero_load = 1'b1;
                else q.push_back(cur_n);
            end
            en_cnt += int'(bus.en_comp);
            exp_done = acc_last | zero_load;
            pv = bus.out_valid;
            pl = bus.out_last;
            pr = bus.out_ready;
            if (sent == 40 && !pending && q.size() == 0) drain++;
            if (drain > 4) break;
        end
        checks++;
        if (pending || q.size() != 0 || sent != 40)
            $display("FAIL rand_timeout got=sent%0d/queued%0d want=40/0", sent, q.size());
        else passes++;
        checks++;
        if (en_cnt != total_beats)
            $display("FAIL rand_en_count got=%0d want=%0d", en_cnt, total_beats);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_single();
        test_zero_tile();
        test_back_to_back();
        test_stall();
        test_reset_mid_tile();
        test_all_ones();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
